// File: rtl/debounce_pkg.sv
// Shared types and LFSR helper for the bounce emulator and debouncer family.
package debounce_pkg;

  localparam int unsigned LfsrWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBounce,
    StSettle
  } bounce_state_e;

  // 16-bit Fibonacci step, taps 16/14/13/11; a non-zero state never maps to zero.
  function automatic logic [LfsrWidth-1:0] lfsr16_next(input logic [LfsrWidth-1:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-period prescaler: one-cycle tick every PrescaleMax cycles, restartable via clr_i.
module tick_gen #(
  parameter int unsigned PrescaleMax = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (PrescaleMax > 1) ? $clog2(PrescaleMax) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(PrescaleMax - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// Switch-bounce emulator: each change of level_i yields a pseudo-random burst on sw_o,
// followed by a stable settle interval and a done pulse.
module bounce_gen
  import debounce_pkg::*;
#(
  parameter int unsigned ClkRate     = 100_000_000,
  parameter int unsigned Baud        = 10_000_000,
  parameter int unsigned BounceTicks = 8,
  parameter int unsigned SettleTicks = 4,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic sw_o,
  output logic busy_o,
  output logic done_tick_o
);

  localparam int unsigned PrescaleMax = ClkRate / Baud;
  localparam int unsigned BcntW = (BounceTicks > 1) ? $clog2(BounceTicks) : 1;
  localparam int unsigned ScntW = (SettleTicks > 1) ? $clog2(SettleTicks) : 1;
  localparam logic [LfsrWidth-1:0] SeedEff = (LfsrSeed == '0) ? 16'h0001 : LfsrSeed;

  if (PrescaleMax < 2) begin : g_bad_prescale
    $error("bounce_gen: ClkRate/Baud must be at least 2");
  end
  if (BounceTicks < 1) begin : g_bad_bounce
    $error("bounce_gen: BounceTicks must be at least 1");
  end
  if (SettleTicks < 1) begin : g_bad_settle
    $error("bounce_gen: SettleTicks must be at least 1");
  end

  bounce_state_e        state_q;
  logic                 target_q;
  logic [LfsrWidth-1:0] lfsr_q;
  logic [BcntW-1:0]     bcnt_q;
  logic [ScntW-1:0]     scnt_q;
  logic                 sw_q, busy_q, done_q;
  logic                 tick;
  logic                 restart;

  // A differing request both starts a burst from idle and restarts one in flight.
  assign restart = (level_i != target_q);

  tick_gen #(
    .PrescaleMax(PrescaleMax)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (restart),
    .tick_o(tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      target_q <= 1'b0;
      lfsr_q   <= SeedEff;
      bcnt_q   <= '0;
      scnt_q   <= '0;
      sw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (restart) begin
        // sw_q is left alone: the bouncy output only moves on ticks.
        target_q <= level_i;
        bcnt_q   <= '0;
        scnt_q   <= '0;
        busy_q   <= 1'b1;
        state_q  <= StBounce;
      end else begin
        case (state_q)
          StBounce: begin
            if (tick) begin
              lfsr_q <= lfsr16_next(lfsr_q);
              if (bcnt_q == BcntW'(BounceTicks - 1)) begin
                sw_q    <= target_q;
                scnt_q  <= '0;
                state_q <= StSettle;
              end else begin
                sw_q   <= lfsr_q[15];
                bcnt_q <= bcnt_q + 1'b1;
              end
            end
          end
          StSettle: begin
            sw_q <= target_q;
            if (tick) begin
              if (scnt_q == ScntW'(SettleTicks - 1)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                scnt_q <= scnt_q + 1'b1;
              end
            end
          end
          default: begin
            sw_q    <= target_q;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign sw_o        = sw_q;
  assign busy_o      = busy_q;
  assign done_tick_o = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen with PrescaleMax=10, BounceTicks=8, SettleTicks=4.
module tb_bounce_gen;

  logic clk_i = 1'b0;
  logic rst_i;
  logic level_i;
  logic sw_o, busy_o, done_tick_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  bounce_gen #(
    .ClkRate    (100),
    .Baud       (10),
    .BounceTicks(8),
    .SettleTicks(4),
    .LfsrSeed   (16'hACE1)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .level_i    (level_i),
    .sw_o       (sw_o),
    .busy_o     (busy_o),
    .done_tick_o(done_tick_o)
  );

  // Loopback debouncer: 10-cycle samples, level accepted after 4 consecutive differing samples.
  int   dpre, drun, db_rises;
  logic db_level, db_tick;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dpre <= 0; drun <= 0; db_level <= 1'b0; db_tick <= 1'b0; db_rises <= 0;
    end else begin
      db_tick <= 1'b0;
      dpre    <= (dpre == 9) ? 0 : dpre + 1;
      if (dpre == 9) begin
        if (sw_o != db_level) begin
          if (drun == 3) begin
            db_level <= sw_o;
            db_tick  <= sw_o;
            drun     <= 0;
            if (sw_o) db_rises <= db_rises + 1;
          end else begin
            drun <= drun + 1;
          end
        end else begin
          drun <= 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expects level_i to have just been driven 0->1 with the LFSR at its seed.
  task automatic burst_check(input string tag);
    logic [6:0] exp7;
    logic       prev;
    int         bad, dones, done_k, n;
    exp7   = 7'b1010110;  // bits 15..9 of 16'hACE1, i.e. l[15] before ticks 1..7
    bad    = 0;
    dones  = 0;
    done_k = -1;
    for (int k = 1; k <= 125; k++) begin
      prev = sw_o;
      step();
      if (k == 1)   chk({tag, "_busy_rise"}, busy_o, 1);
      if (k == 120) chk({tag, "_busy_settle"}, busy_o, 1);
      if ((k % 10 == 1) && (k > 1) && (k <= 81)) begin
        n = k / 10;
        chk($sformatf("%s_tick%0d", tag, n), sw_o, (n <= 7) ? exp7[7-n] : 1'b1);
      end else if ((k % 10 != 1) && (sw_o != prev)) begin
        bad++;
      end
      if (done_tick_o) begin
        dones++;
        done_k = k;
      end
    end
    chk({tag, "_offtick_changes"}, bad, 0);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_done_latency"}, done_k, 121);
    chk({tag, "_busy_end"}, busy_o, 0);
    chk({tag, "_sw_end"}, sw_o, 1);
  endtask

  initial begin
    int   dones, done_k;
    logic found;
    logic [4:0] seq;

    // Test 1: reset
    rst_i   = 1'b1;
    level_i = 1'b0;
    step(); step();
    chk("rst_sw", sw_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_tick_o, 0);
    rst_i = 1'b0;
    step(); step(); step();
    chk("idle_sw", sw_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_tick_o, 0);

    // Tests 2/3: full burst from seed
    level_i = 1'b1;
    burst_check("t2");

    // Test 4: restart with target 0 after burst tick 4
    rst_i = 1'b1; level_i = 1'b0;
    step();
    rst_i = 1'b0;
    step(); step();
    level_i = 1'b1;
    for (int k = 1; k <= 41; k++) step();
    chk("t4_tick4", sw_o, 0);
    level_i = 1'b0;
    dones  = 0;
    done_k = -1;
    for (int k = 1; k <= 130; k++) begin
      step();
      if (k == 1) chk("t4_busy_restart", busy_o, 1);
      if (done_tick_o) begin
        dones++;
        done_k = k;
      end
    end
    chk("t4_done_count", dones, 1);
    chk("t4_done_latency", done_k, 121);
    chk("t4_sw_end", sw_o, 0);
    chk("t4_busy_end", busy_o, 0);

    // Test 6: async reset at burst tick 3, then fresh burst from seed
    rst_i = 1'b1; level_i = 1'b0;
    step();
    rst_i = 1'b0;
    step(); step();
    level_i = 1'b1;
    for (int k = 1; k <= 31; k++) step();
    chk("t6_tick3", sw_o, 1);
    chk("t6_busy_pre", busy_o, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("t6_async_sw", sw_o, 0);
    chk("t6_async_busy", busy_o, 0);
    step(); step();
    rst_i = 1'b0;
    burst_check("t6");

    // Test 5: loopback into the debouncer over five requests
    rst_i = 1'b1; level_i = 1'b0;
    step();
    rst_i = 1'b0;
    step(); step();
    chk("t5_db_init", db_level, 0);
    seq = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      level_i = seq[i];
      found   = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
        step();
        if (done_tick_o) found = 1'b1;
      end
      chk($sformatf("t5_done_%0d", 4 - i), found, 1);
      step(); step();
      chk($sformatf("t5_db_level_%0d", 4 - i), db_level, seq[i]);
      for (int k = 0; k < 20; k++) step();
    end
    chk("t5_db_rises", db_rises, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
